// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding and default parameters for the serial
// pattern generator.
//   IDLE/SHIFT/GAP/FIN : 2-bit FSM state codes
//   DEF_*              : default parameter values used by seq_gen and its shift register
package seq_gen_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_LEN_W = 5;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_GAP_W = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;
endpackage

// File: rtl/seq_gen_shreg.sv
// seq_gen_shreg: WIDTH-bit left-shift register that left-aligns a len-bit
// pattern on load so bit len-1 sits at the MSB.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (highest priority)
//   load       : load data aligned by len
//   shift      : shift left by one, zero-filling
//   data, len  : pattern word and its length in bits
//   msb        : current MSB (registered)
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    output logic             msb
);
    logic [WIDTH-1:0] sr;

    // Alignment discards pattern bits above len-1, so after len shifts the
    // register is all zeros and msb reads 0 outside SHIFT without gating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     sr <= '0;
        else if (clr)   sr <= '0;
        else if (load)  sr <= data << (LEN_W'(WIDTH) - len);
        else if (shift) sr <= {sr[WIDTH-2:0], 1'b0};
    end

    assign msb = sr[WIDTH-1];
endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator, sends a pattern MSB-first reps times with
// gap idle cycles between repeats.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request, accepted when ready=1
//   pattern, len    : bits to send (bit len-1 first) and bits per repeat
//   reps, gap       : repeat count and idle cycles between repeats
//   abort           : synchronous cancel of an active transfer
//   ready, busy     : idle / transfer active
//   out_bit         : serial data, 0 whenever out_valid=0
//   out_valid, done : bit qualifier and one-cycle completion pulse
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             out_bit,
    output logic             out_valid,
    output logic             done
);
    logic [1:0]       state, nxt;
    logic [LEN_W-1:0] bit_cnt, bit_n, len_q, len_c;
    logic [CNT_W-1:0] rep_cnt, rep_n;
    logic [GAP_W-1:0] gap_cnt, gap_n, gap_q;
    logic [WIDTH-1:0] pat_q;
    logic             load, shift, clr, accept;

    assign len_c  = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    assign accept = (state == IDLE) && start;

    always_comb begin
        nxt   = state;
        bit_n = bit_cnt;
        rep_n = rep_cnt;
        gap_n = gap_cnt;
        load  = 1'b0;
        shift = 1'b0;
        clr   = 1'b0;
        if (state != IDLE && abort) begin
            nxt   = IDLE;
            clr   = 1'b1;
            bit_n = '0;
            rep_n = '0;
            gap_n = '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    bit_n = len_c;
                    rep_n = reps;
                    gap_n = '0;
                    nxt   = (len_c == '0 || reps == '0) ? FIN : SHIFT;
                    load  = (len_c != '0 && reps != '0);
                end
                SHIFT: begin
                    shift = 1'b1;
                    bit_n = bit_cnt - 1'b1;
                    if (bit_cnt == LEN_W'(1)) begin
                        if (rep_cnt == CNT_W'(1)) begin
                            nxt   = FIN;
                            rep_n = '0;
                        end else begin
                            rep_n = rep_cnt - 1'b1;
                            // zero gap reloads on the same edge, no bubble
                            nxt   = (gap_q != '0) ? GAP : SHIFT;
                            gap_n = gap_q;
                            load  = (gap_q == '0);
                            bit_n = (gap_q == '0) ? len_q : '0;
                        end
                    end
                end
                GAP: begin
                    gap_n = gap_cnt - 1'b1;
                    if (gap_cnt == GAP_W'(1)) begin
                        nxt   = SHIFT;
                        load  = 1'b1;
                        bit_n = len_q;
                    end
                end
                FIN: begin
                    nxt   = IDLE;
                    bit_n = '0;
                    rep_n = '0;
                    gap_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rep_cnt   <= '0;
            gap_cnt   <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt;
            bit_cnt   <= bit_n;
            rep_cnt   <= rep_n;
            gap_cnt   <= gap_n;
            ready     <= (nxt == IDLE);
            busy      <= (nxt != IDLE);
            out_valid <= (nxt == SHIFT);
            done      <= (nxt == FIN);
            if (accept) begin
                pat_q <= pattern;
                len_q <= len_c;
                gap_q <= gap;
            end
        end
    end

    // Reload comes from the latched copy; the first load takes the live inputs.
    seq_gen_shreg #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .load  (load),
        .shift (shift),
        .data  (state == IDLE ? pattern : pat_q),
        .len   (state == IDLE ? len_c : len_q),
        .msb   (out_bit)
    );
endmodule
